// File: rtl/md_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM state encoding and the default datapath width.
package md_pkg;

  localparam int MD_DATA_WIDTH = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation: converts a signed value to its
// magnitude on the way in, and restores the sign on the way out.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide
// step per cycle on magnitudes, sign restored in a final FIX cycle.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [2:0]            MD_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic [DATA_WIDTH-1:0] Result_o,
  output logic                  Zero_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  md_state_e       state_q;
  logic [2:0]      op_q;
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    opb_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic [W-1:0]    a_raw_q;
  logic            b_zero_q;
  logic [W-1:0]    result_q;
  logic            zero_q;

  // Operand signedness and result sign, decoded from the incoming request.
  logic         in_div, a_signed, b_signed, a_neg, b_neg, res_neg;
  logic [W-1:0] a_mag, b_mag;

  assign in_div   = MD_Operation_i[2];
  assign a_signed = in_div ? ~MD_Operation_i[0] : (MD_Operation_i[1:0] != 2'b11);
  assign b_signed = in_div ? ~MD_Operation_i[0] : ~MD_Operation_i[1];
  assign a_neg    = a_signed & A_i[W-1];
  assign b_neg    = b_signed & B_i[W-1];
  assign res_neg  = (in_div & MD_Operation_i[1]) ? a_neg : (a_neg ^ b_neg);

  md_sign_fix #(.W(W)) u_fix_a (.val_i(A_i), .neg_i(a_neg), .val_o(a_mag));
  md_sign_fix #(.W(W)) u_fix_b (.val_i(B_i), .neg_i(b_neg), .val_o(b_mag));

  // One iteration of each algorithm on the shared {hi, lo} register.
  logic [W:0]     mul_sum, div_trial;
  logic [2*W-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opb_q : '0)};
  assign mul_next  = {mul_sum, acc_q[W-1:1]};
  assign div_trial = acc_q[2*W-1:W-1] - {1'b0, opb_q};
  assign div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                  : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};

  // Result selection and sign restore; the 2W-bit fixer covers the full product.
  logic           is_div_q, is_rem_q;
  logic [2*W-1:0] fix_in, fix_out;
  logic [W-1:0]   result_d;

  assign is_div_q = op_q[2];
  assign is_rem_q = op_q[2] & op_q[1];
  assign fix_in   = is_div_q ? {{W{1'b0}}, (is_rem_q ? acc_q[2*W-1:W] : acc_q[W-1:0])}
                             : acc_q;

  md_sign_fix #(.W(2*W)) u_fix_r (.val_i(fix_in), .neg_i(neg_q), .val_o(fix_out));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    result_d = fix_out[W-1:0];
    if (is_div_q && b_zero_q)
      result_d = is_rem_q ? a_raw_q : '1;
    else if (!is_div_q && (op_q != MD_MUL))
      result_d = fix_out[2*W-1:W];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      a_raw_q  <= '0;
      b_zero_q <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (Start_i) begin
            op_q     <= MD_Operation_i;
            acc_q    <= {{W{1'b0}}, (in_div ? a_mag : b_mag)};
            opb_q    <= in_div ? b_mag : a_mag;
            neg_q    <= res_neg;
            a_raw_q  <= A_i;
            b_zero_q <= (B_i == '0);
            cnt_q    <= '0;
            state_q  <= ST_CALC;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= result_d;
          zero_q   <= (result_d == '0);
          state_q  <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Busy_o   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign Done_o   = (state_q == ST_DONE);
  assign Result_o = result_q;
  assign Zero_o   = zero_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative RV32M multiply/divide unit for the core's M-extension ops. It complements the single-cycle combinational integer ALU. The decode stage issues one op plus operands with a start pulse; the unit runs a fixed-latency shift/add or restoring-divide sequence and returns a registered 32-bit result with a done pulse. It shares the ALU's operand/result width and Zero flag semantics.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Start_i  input  1  request strobe; sampled only when Busy_o=0
MD_Operation_i  input  3  funct3: MUL=000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111
A_i  input  DATA_WIDTH  rs1 operand (multiplicand/dividend)
B_i  input  DATA_WIDTH  rs2 operand (multiplier/divisor)
Busy_o  output  1  high while an op is in flight (CALC or FIX)
Done_o  output  1  one-cycle pulse: Result_o valid
Result_o  output  DATA_WIDTH  registered result, held until the next Done_o
Zero_o  output  1  registered (Result_o == 0), updated with Result_o

Behaviour:
- Reset (async, reset=0): state IDLE; Busy_o=0, Done_o=0, Result_o=0, Zero_o=0; all internal regs cleared. Reset mid-op aborts with no Done_o.
- States: IDLE, CALC, FIX, DONE. Busy_o = (CALC|FIX). Done_o = (DONE).
- IDLE/DONE + Start_i=1 at edge 0: capture op, take operand magnitudes per signedness, record result sign, clear counter -> CALC. DONE without Start_i -> IDLE. Back-to-back starts are accepted in DONE.
- Start_i while Busy_o=1: ignored; no queuing; captured op and operands are unaffected.
- CALC, edges 1..DATA_WIDTH: one iteration per cycle.
  - Multiply: 2*DATA_WIDTH-bit shift-add on magnitudes.
  - Divide: restoring shift-subtract yielding quotient and remainder magnitudes.
  - Counter reaches DATA_WIDTH-1 -> FIX.
- FIX, edge DATA_WIDTH+1: apply sign, select the result, register Result_o/Zero_o -> DONE. Fixed latency: Done_o is high between edges DATA_WIDTH+1 and DATA_WIDTH+2 (edges 33..34 at default). Latency is constant for every op, including the special cases below.
- Signedness:
  - MULH: both operands signed. MULHSU: A signed, B unsigned. MULHU, DIVU, REMU: unsigned.
  - MUL returns the low half; MUL* ops return the high half of the 64-bit product.
- Division sign: quotient negative iff operand signs differ (DIV). Remainder takes the dividend's sign (REM).
- Divide by zero: DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> A_i unchanged. No trap.
- Signed overflow (DIV, A=0x80000000, B=0xFFFFFFFF): quotient 0x80000000; REM -> 0.
- Result_o/Zero_o change only in FIX; held through IDLE.

Decomposition:
- Shared package md_pkg: funct3 localparams (MD_MUL..MD_REMU), state encoding, DATA_WIDTH default.
- Single module; the shared 2*DATA_WIDTH accumulator/shift register serves both mul and div.
- Optional sub-module md_sign_fix (combinational magnitude/sign-restore helper), used on both the input and output sides.

Test Plan:
- Reset, then MUL A=7 B=0xFFFFFFFD (-3) -> Done_o exactly at edge 33 after start; Result_o=0xFFFFFFEB; Zero_o=0; Busy_o high across edges 0..32.
- MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE. MULH A=B=0xFFFFFFFF -> 0x00000000 with Zero_o=1. MULHSU A=0xFFFFFFFF B=2 -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7) B=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0xFFFFFFF9/0 -> 0xFFFFFFFF. Latency stays 34 cycles.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0, Zero_o=1.
- Pulse Start_i with new operands at cycle 10 of an op -> ignored; original result returned. Assert reset at cycle 20 -> Busy_o=0, Result_o=0, no Done_o. Start in DONE -> second op completes 34 cycles later.
